// File: rtl/dcache_writeback_unit.sv
// Write-back buffer for one evicted dirty cache line. The line is captured in a
// single handshake, then drained to memory as ascending word stores with one
// store outstanding at a time. While buffered, the line can be looked up
// combinationally so pending data can be forwarded to loads.
module dcache_writeback_unit #(
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned PLEN       = 34,
    parameter logic [1:0]  MEM_TID    = 2'd0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // line capture from the cache controller
    input  logic                  wb_valid_i,
    output logic                  wb_ready_o,
    input  logic [PLEN-1:0]       wb_addr_i,
    input  logic [LINE_WIDTH-1:0] wb_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    // forwarding lookup
    input  logic [PLEN-1:0]       lookup_addr_i,
    output logic                  lookup_hit_o,
    output logic [XLEN-1:0]       lookup_data_o,
    // memory request / return
    output logic                  mem_req_o,
    input  logic                  mem_ack_i,
    output logic [PLEN-1:0]       mem_addr_o,
    output logic [XLEN-1:0]       mem_wdata_o,
    output logic [2:0]            mem_size_o,
    output logic [1:0]            mem_tid_o,
    input  logic                  mem_rtrn_vld_i,
    input  logic                  mem_rtrn_st_ack_i,
    input  logic [1:0]            mem_rtrn_tid_i
);

    localparam int unsigned NWORDS = LINE_WIDTH / XLEN;
    localparam int unsigned OFFS   = $clog2(LINE_WIDTH / 8);
    localparam int unsigned WIDX   = $clog2(NWORDS);
    // byte-offset bits inside one word
    localparam int unsigned BOFFS  = OFFS - WIDX;
    localparam int unsigned TAGW   = PLEN - OFFS;
    localparam logic [WIDX-1:0] LAST_WORD = WIDX'(NWORDS - 1);

    typedef enum logic [1:0] {StIdle, StSend, StWaitRtrn} state_e;

    state_e                        state_q, state_d;
    logic [WIDX-1:0]               cnt_q, cnt_d;
    logic [TAGW-1:0]               tag_q, tag_d;
    logic [NWORDS-1:0][XLEN-1:0]   line_q, line_d;
    logic                          rtrn_match;
    logic                          last_word;
    logic                          unused_addr_bits;

    // Only store acks carrying our own transaction ID count as completions.
    assign rtrn_match = mem_rtrn_vld_i && mem_rtrn_st_ack_i && (mem_rtrn_tid_i == MEM_TID);
    assign last_word  = (cnt_q == LAST_WORD);

    // Byte offsets within a line/word do not affect the unit.
    assign unused_addr_bits = ^{wb_addr_i[OFFS-1:0], lookup_addr_i[BOFFS-1:0]};

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: capture, issue one store, wait for its ack, repeat.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (wb_valid_i) state_d = StSend;
            end
            StSend: begin
                if (mem_ack_i) state_d = StWaitRtrn;
            end
            StWaitRtrn: begin
                if (rtrn_match) state_d = last_word ? StIdle : StSend;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode; request fields come straight from registers so they stay
    // stable while the memory applies backpressure.
    always_comb begin
        wb_ready_o    = (state_q == StIdle);
        busy_o        = (state_q != StIdle);
        mem_req_o     = (state_q == StSend);
        done_o        = (state_q == StWaitRtrn) && rtrn_match && last_word;
        mem_addr_o    = {tag_q, cnt_q, {BOFFS{1'b0}}};
        mem_wdata_o   = line_q[cnt_q];
        mem_size_o    = 3'b010;
        mem_tid_o     = MEM_TID;
        lookup_hit_o  = (state_q != StIdle) && (lookup_addr_i[PLEN-1:OFFS] == tag_q);
        lookup_data_o = line_q[lookup_addr_i[OFFS-1:BOFFS]];
    end

    // Datapath next state: the buffer only changes on capture, the word
    // counter advances on each non-final store ack.
    always_comb begin
        tag_d  = tag_q;
        line_d = line_q;
        cnt_d  = cnt_q;
        if ((state_q == StIdle) && wb_valid_i) begin
            tag_d  = wb_addr_i[PLEN-1:OFFS];
            line_d = wb_data_i;
            cnt_d  = '0;
        end else if ((state_q == StWaitRtrn) && rtrn_match && !last_word) begin
            cnt_d = cnt_q + WIDX'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_q  <= '0;
            line_q <= '0;
            cnt_q  <= '0;
        end else begin
            tag_q  <= tag_d;
            line_q <= line_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule
